add_shift_core: RTL and testbench

ADD_SHIFT_CORE -- requirements
Module: add_shift

---
 rtl/add_shift_core_pkg.sv | 14 +
 rtl/add_shift_core_if.sv | 28 ++
 rtl/add_shift_core_lift_stage.sv | 30 +++
 rtl/add_shift_core.sv | 85 ++++++++
 tb/tb_add_shift_core.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/add_shift_core_pkg.sv
// Shared definitions for the 5/3 lifting core: default sample width and sample type.
package add_shift_core_pkg;

  localparam int W_DEFAULT = 19;

  typedef logic signed [W_DEFAULT-1:0] sample_t;

  // Lifting step constants: predict halves the neighbour sum, update quarters it with rounding.
  localparam int PREDICT_SHIFT = 1;
  localparam int PREDICT_RND   = 0;
  localparam int UPDATE_SHIFT  = 2;
  localparam int UPDATE_RND    = 2;

endpackage : add_shift_core_pkg

// File: rtl/add_shift_core_if.sv
// Beat interface of the lifting core: one window per in_valid beat, one result per out_valid.
interface add_shift_core_if
  import add_shift_core_pkg::*;
#(
  parameter int W = W_DEFAULT
);

  logic                in_valid;
  logic                sof;
  logic signed [W-1:0] x2;
  logic signed [W-1:0] x3;
  logic signed [W-1:0] x4;
  logic signed [W-1:0] x5;
  logic signed [W-1:0] d3;
  logic signed [W-1:0] a2;
  logic                out_valid;

  modport master (
    output in_valid, sof, x2, x3, x4, x5,
    input  d3, a2, out_valid
  );

  modport slave (
    input  in_valid, sof, x2, x3, x4, x5,
    output d3, a2, out_valid
  );

endinterface : add_shift_core_if

// File: rtl/add_shift_core_lift_stage.sv
// One lifting step: result = base -/+ ((p + q + RND) >>> SHIFT), wrapped to W bits.
module add_shift_core_lift_stage #(
  parameter int W        = 19,
  parameter int SHIFT    = 1,
  parameter int RND      = 0,
  parameter bit SUBTRACT = 1'b1
) (
  input  logic signed [W-1:0] base,
  input  logic signed [W-1:0] p,
  input  logic signed [W-1:0] q,
  output logic signed [W-1:0] result
);

  // Two guard bits hold p + q + RND without overflow before the floor shift.
  localparam int SW = W + 2;

  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] scaled;

  always_comb begin
    sum    = SW'(p) + SW'(q) + SW'(RND);
    scaled = sum >>> SHIFT;
    if (SUBTRACT) begin
      result = W'(SW'(base) - scaled);
    end else begin
      result = W'(SW'(base) + scaled);
    end
  end

endmodule : add_shift_core_lift_stage

// File: rtl/add_shift_core.sv
// Two-stage 5/3 lifting core: stage 1 predicts d3, stage 2 updates a2 using the previous d3.
module add_shift_core
  import add_shift_core_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  add_shift_core_if.slave    bus
);

  logic signed [W-1:0] d3_comb;
  logic signed [W-1:0] a2_comb;
  logic signed [W-1:0] d1_sel;

  logic signed [W-1:0] d3_s1;
  logic signed [W-1:0] x2_s1;
  logic                valid_s1;
  logic                self_s1;

  logic signed [W-1:0] d1_hist;
  logic                first_q;

  add_shift_core_lift_stage #(
    .W        (W),
    .SHIFT    (PREDICT_SHIFT),
    .RND      (PREDICT_RND),
    .SUBTRACT (1'b1)
  ) u_predict (
    .base   (bus.x3),
    .p      (bus.x2),
    .q      (bus.x4),
    .result (d3_comb)
  );

  // Left row boundary mirrors the current detail coefficient instead of using history.
  always_comb begin
    d1_sel = self_s1 ? d3_s1 : d1_hist;
  end

  add_shift_core_lift_stage #(
    .W        (W),
    .SHIFT    (UPDATE_SHIFT),
    .RND      (UPDATE_RND),
    .SUBTRACT (1'b0)
  ) u_update (
    .base   (x2_s1),
    .p      (d1_sel),
    .q      (d3_s1),
    .result (a2_comb)
  );

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_s1      <= 1'b0;
      self_s1       <= 1'b0;
      d3_s1         <= '0;
      x2_s1         <= '0;
      d1_hist       <= '0;
      first_q       <= 1'b1;
      bus.d3        <= '0;
      bus.a2        <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      valid_s1      <= bus.in_valid;
      bus.out_valid <= valid_s1;

      if (bus.in_valid) begin
        d3_s1   <= d3_comb;
        x2_s1   <= bus.x2;
        self_s1 <= bus.sof | first_q;
        first_q <= 1'b0;
      end

      // Bubbles leave outputs and d1 history untouched.
      if (valid_s1) begin
        bus.d3  <= d3_s1;
        bus.a2  <= a2_comb;
        d1_hist <= d3_s1;
      end
    end
  end

endmodule : add_shift_core

// File: tb/tb_add_shift_core.sv
// Directed bench for add_shift_core: table of back-to-back beats plus reset/bubble sequences.
module tb_add_shift_core;
  import add_shift_core_pkg::*;

  localparam int W    = W_DEFAULT;
  localparam int MAXV = (1 << (W - 1)) - 1;
  localparam int MINV = -(1 << (W - 1));

  typedef struct {
    logic                vld;
    logic                sof;
    logic signed [W-1:0] x2;
    logic signed [W-1:0] x3;
    logic signed [W-1:0] x4;
    logic signed [W-1:0] x5;
    logic signed [W-1:0] exp_d3;
    logic signed [W-1:0] exp_a2;
  } vec_t;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;

  vec_t tbl [0:9];
  vec_t seq [0:15];

  add_shift_core_if #(.W(W)) bus ();

  add_shift_core #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input bit vld, input bit sof, input int x2, input int x3,
                              input int x4, input int x5, input int ed3, input int ea2);
    vec_t v;
    v.vld    = vld;
    v.sof    = sof;
    v.x2     = W'(x2);
    v.x3     = W'(x3);
    v.x4     = W'(x4);
    v.x5     = W'(x5);
    v.exp_d3 = W'(ed3);
    v.exp_a2 = W'(ea2);
    return v;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.in_valid = v.vld;
    bus.sof      = v.sof;
    bus.x2       = v.x2;
    bus.x3       = v.x3;
    bus.x4       = v.x4;
    bus.x5       = v.x5;
  endtask

  task automatic drive_idle();
    bus.in_valid = 1'b0;
    bus.sof      = 1'b0;
  endtask

  // Streams seq[0..n-1] one slot per cycle and checks each slot's result two cycles later.
  task automatic run_seq(input string tag, input int n);
    for (int k = 0; k < n + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        check($sformatf("%s[%0d].out_valid", tag, k - 2), int'(bus.out_valid), int'(seq[k-2].vld));
        if (seq[k-2].vld) begin
          check($sformatf("%s[%0d].d3", tag, k - 2), int'(bus.d3), int'(seq[k-2].exp_d3));
          check($sformatf("%s[%0d].a2", tag, k - 2), int'(bus.a2), int'(seq[k-2].exp_a2));
        end
      end
      if (k < n) drive(seq[k]);
      else drive_idle();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Back-to-back beats; d1 carries across sof=0 beats.
    tbl[0] = mk(1, 1,  164,  164,  164, 164,       0,    164);
    tbl[1] = mk(1, 1,  156,  148,  112, 132,      14,    163);
    tbl[2] = mk(1, 1,  164,  164,  164, 164,       0,    164);
    tbl[3] = mk(1, 0,  156,  148,  112, 132,      14,    160);
    tbl[4] = mk(1, 1,   -3,    0,    0,   0,       2,     -2);
    tbl[5] = mk(1, 0,   10,   20,   30,   0,       0,     11);
    tbl[6] = mk(1, 1, MAXV, MINV, MAXV,   0,       1,   MINV);
    tbl[7] = mk(1, 1, MINV, MINV, MINV,   0,       0,   MINV);
    tbl[8] = mk(1, 1,    0, MAXV, MINV,   0, -131073, -65536);
    tbl[9] = mk(1, 0,    5,   -7,    2,   0,     -10, -32766);

    rst_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    check("reset.d3", int'(bus.d3), 0);
    check("reset.a2", int'(bus.a2), 0);
    check("reset.out_valid", int'(bus.out_valid), 0);
    rst_n = 1'b1;

    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        check($sformatf("tbl[%0d].out_valid", k - 2), int'(bus.out_valid), 1);
        check($sformatf("tbl[%0d].d3", k - 2), int'(bus.d3), int'(tbl[k-2].exp_d3));
        check($sformatf("tbl[%0d].a2", k - 2), int'(bus.a2), int'(tbl[k-2].exp_a2));
      end
      if (k < 10) drive(tbl[k]);
      else drive_idle();
    end

    // x5 toggle leaves results unchanged; a bubble keeps d1 history for the next beat.
    seq[0] = mk(1, 1, 156, 148, 112, 164, 14, 163);
    seq[1] = mk(1, 0, 156, 148, 112, 164, 14, 163);
    seq[2] = mk(1, 0, 156, 148, 112, 132, 14, 163);
    seq[3] = mk(0, 0, 999, 999, 999, 999,  0,   0);
    seq[4] = mk(1, 0, 100,  50,   0,   7,  0, 104);
    run_seq("bubble", 5);

    // Reset with two beats in flight: outputs clear, beats vanish.
    @(negedge clk);
    drive(mk(1, 1, 156, 148, 112, 132, 0, 0));
    @(negedge clk);
    drive(mk(1, 1, 164, 164, 164, 164, 0, 0));
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst.d3", int'(bus.d3), 0);
    check("midrst.a2", int'(bus.a2), 0);
    check("midrst.out_valid", int'(bus.out_valid), 0);
    rst_n = 1'b1;
    drive_idle();
    @(negedge clk);
    check("midrst.flush1", int'(bus.out_valid), 0);
    @(negedge clk);
    check("midrst.flush2", int'(bus.out_valid), 0);

    // First beat after reset self-extends even with sof=0.
    seq[0] = mk(1, 0, 156, 148, 112, 132, 14, 163);
    seq[1] = mk(1, 0, 156, 148, 112, 132, 14, 163);
    run_seq("first", 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_add_shift_core
